// File: rtl/instruction_register_multi.sv
// rtl/instruction_register_multi.sv - instruction byte plus multi-byte operand assembly register
module instruction_register_multi #(
    parameter int BUS_W        = 8,
    parameter int OPC_W        = 4,
    parameter int MAX_OPERANDS = 2,
    parameter int ADDR_W       = BUS_W * MAX_OPERANDS,
    parameter int CNT_W        = $clog2(MAX_OPERANDS + 1)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [BUS_W-1:0]  i_bus,
    input  logic              i_load_instruction,
    input  logic              i_load_operand,
    input  logic              i_send_address,
    input  logic [CNT_W-1:0]  i_operand_count,
    output logic [OPC_W-1:0]  o_opcode,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_complete,
    output logic              o_error
);

    typedef enum logic [1:0] {EMPTY, DECODE, OPERAND, COMPLETE} state_t;

    // Declaration initialisers give the reset state at power-up without a reset pulse.
    state_t            state_q    = EMPTY;
    logic [BUS_W-1:0]  instr_q    = '0;
    logic [ADDR_W-1:0] operands_q = '0;
    logic [CNT_W-1:0]  index_q    = '0;
    logic [CNT_W-1:0]  count_q    = '0;
    logic              error_q    = 1'b0;
    logic              complete_q = 1'b0;

    logic [ADDR_W-1:0] address_d;
    logic [CNT_W-1:0]  index_inc;

    assign index_inc = index_q + CNT_W'(1);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= EMPTY;
            instr_q    <= '0;
            operands_q <= '0;
            index_q    <= '0;
            count_q    <= '0;
            error_q    <= 1'b0;
            complete_q <= 1'b0;
        end else if (i_load_instruction) begin
            state_q    <= DECODE;
            instr_q    <= i_bus;
            operands_q <= '0;
            index_q    <= '0;
            count_q    <= '0;
            error_q    <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            case (state_q)
                DECODE: begin
                    if (i_operand_count == '0) begin
                        state_q    <= COMPLETE;
                        complete_q <= 1'b1;
                    end else if (i_operand_count > CNT_W'(MAX_OPERANDS)) begin
                        state_q    <= COMPLETE;
                        error_q    <= 1'b1;
                        complete_q <= 1'b1;
                    end else begin
                        state_q <= OPERAND;
                        count_q <= i_operand_count;
                    end
                end
                OPERAND: begin
                    if (i_load_operand) begin
                        for (int k = 0; k < MAX_OPERANDS; k++) begin
                            if (index_q == CNT_W'(k)) begin
                                operands_q[k*BUS_W +: BUS_W] <= i_bus;
                            end
                        end
                        index_q <= index_inc;
                        if (index_inc == count_q) begin
                            state_q    <= COMPLETE;
                            complete_q <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Zero-operand and error instructions carry a short address in the low instruction bits.
    always_comb begin
        address_d = operands_q;
        if (count_q == '0 || error_q) begin
            address_d = ADDR_W'(instr_q[BUS_W-OPC_W-1:0]);
        end
    end

    assign o_opcode   = instr_q[BUS_W-1 -: OPC_W];
    assign o_complete = complete_q;
    assign o_error    = error_q;
    assign o_address  = i_send_address ? address_d : {ADDR_W{1'bz}};

endmodule

// File: tb/tb_instruction_register_multi.sv
// tb/tb_instruction_register_multi.sv - self-checking bench for instruction_register_multi
module tb_instruction_register_multi;

    localparam int BUS_W        = 8;
    localparam int OPC_W        = 4;
    localparam int MAX_OPERANDS = 2;
    localparam int ADDR_W       = BUS_W * MAX_OPERANDS;
    localparam int CNT_W        = $clog2(MAX_OPERANDS + 1);

    logic              i_clock            = 1'b0;
    logic              i_reset            = 1'b0;
    logic [BUS_W-1:0]  i_bus              = '0;
    logic              i_load_instruction = 1'b0;
    logic              i_load_operand     = 1'b0;
    logic              i_send_address     = 1'b0;
    logic [CNT_W-1:0]  i_operand_count    = '0;
    logic [OPC_W-1:0]  o_opcode;
    wire  [ADDR_W-1:0] o_address;
    logic              o_complete;
    logic              o_error;

    int tests_run = 0;
    int tests_failed = 0;

    // A released bus floats high so that high-Z is observable as all ones.
    for (genvar k = 0; k < ADDR_W; k++) begin : g_pu
        pullup (o_address[k]);
    end

    instruction_register_multi #(
        .BUS_W(BUS_W), .OPC_W(OPC_W), .MAX_OPERANDS(MAX_OPERANDS)
    ) dut (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .i_bus(i_bus),
        .i_load_instruction(i_load_instruction),
        .i_load_operand(i_load_operand),
        .i_send_address(i_send_address),
        .i_operand_count(i_operand_count),
        .o_opcode(o_opcode),
        .o_address(o_address),
        .o_complete(o_complete),
        .o_error(o_error)
    );

    always #5 i_clock = ~i_clock;

    // Model: phase 0 idle, 1 awaiting decode, 2 collecting operands, 3 done.
    int         m_phase = 0;
    int         m_instr = 0;
    int         m_need  = 0;
    int         m_nops  = 0;
    bit         m_err   = 1'b0;
    int         m_ops [MAX_OPERANDS];

    initial for (int k = 0; k < MAX_OPERANDS; k++) m_ops[k] = 0;

    always @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            m_phase <= 0;
            m_instr <= 0;
            m_need  <= 0;
            m_nops  <= 0;
            m_err   <= 1'b0;
            for (int k = 0; k < MAX_OPERANDS; k++) m_ops[k] <= 0;
        end else if (i_load_instruction) begin
            m_phase <= 1;
            m_instr <= int'(i_bus);
            m_need  <= 0;
            m_nops  <= 0;
            m_err   <= 1'b0;
            for (int k = 0; k < MAX_OPERANDS; k++) m_ops[k] <= 0;
        end else if (m_phase == 1) begin
            if (int'(i_operand_count) == 0) begin
                m_phase <= 3;
            end else if (int'(i_operand_count) > MAX_OPERANDS) begin
                m_phase <= 3;
                m_err   <= 1'b1;
            end else begin
                m_phase <= 2;
                m_need  <= int'(i_operand_count);
            end
        end else if (m_phase == 2 && i_load_operand) begin
            m_ops[m_nops] <= int'(i_bus);
            m_nops        <= m_nops + 1;
            if (m_nops + 1 == m_need) m_phase <= 3;
        end
    end

    function automatic int model_addr();
        int a = 0;
        if (m_need == 0 || m_err) begin
            a = m_instr % (1 << (BUS_W - OPC_W));
        end else begin
            for (int k = 0; k < MAX_OPERANDS; k++) a += m_ops[k] * (1 << (BUS_W * k));
        end
        return a;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge i_clock) begin
        check("cyc_opcode", 64'(o_opcode), 64'(m_instr / (1 << (BUS_W - OPC_W))));
        check("cyc_complete", 64'(o_complete), 64'(m_phase == 3));
        check("cyc_error", 64'(o_error), 64'(m_err));
        if (i_send_address) check("cyc_address", 64'(o_address), 64'(model_addr()));
        else check("cyc_address_z", 64'(o_address), 64'({ADDR_W{1'b1}}));
    end

    task automatic drive(input bit li, input bit lo, input logic [BUS_W-1:0] bus,
                         input int cnt, input bit send);
        @(negedge i_clock);
        #1;
        i_load_instruction = li;
        i_load_operand     = lo;
        i_bus              = bus;
        i_operand_count    = CNT_W'(cnt);
        i_send_address     = send;
        @(posedge i_clock);
        #1;
    endtask

    initial begin
        #2;
        check("powerup_complete", 64'(o_complete), 64'(0));
        check("powerup_opcode", 64'(o_opcode), 64'(0));

        // 0x2E with no operands.
        drive(1, 0, 8'h2E, 0, 1);
        check("c0_edge1_complete", 64'(o_complete), 64'(0));
        drive(0, 0, 8'h00, 0, 1);
        check("c0_complete", 64'(o_complete), 64'(1));
        check("c0_opcode", 64'(o_opcode), 64'h2);
        check("c0_address", 64'(o_address), 64'h000E);
        i_send_address = 1'b0;
        #1;
        check("c0_address_z", 64'(o_address), 64'hFFFF);

        // 0x31 with two operands.
        drive(1, 0, 8'h31, 2, 1);
        drive(0, 0, 8'h00, 2, 1);
        check("c2_decode_complete", 64'(o_complete), 64'(0));
        drive(0, 1, 8'h34, 2, 1);
        check("c2_partial_address", 64'(o_address), 64'h0034);
        check("c2_partial_complete", 64'(o_complete), 64'(0));
        drive(0, 1, 8'h12, 2, 1);
        check("c2_complete", 64'(o_complete), 64'(1));
        check("c2_address", 64'(o_address), 64'h1234);
        check("c2_opcode", 64'(o_opcode), 64'h3);
        drive(0, 1, 8'h99, 2, 1);
        check("complete_ignore_addr", 64'(o_address), 64'h1234);
        check("complete_ignore_cpl", 64'(o_complete), 64'(1));

        // Over-count request.
        drive(1, 0, 8'h5A, 3, 1);
        drive(0, 0, 8'h00, 3, 1);
        check("err_flag", 64'(o_error), 64'(1));
        check("err_complete", 64'(o_complete), 64'(1));
        check("err_address", 64'(o_address), 64'h000A);
        drive(1, 0, 8'h40, 0, 1);
        check("err_cleared", 64'(o_error), 64'(0));

        // Instruction and operand on the same edge mid-OPERAND.
        drive(1, 0, 8'h71, 2, 1);
        drive(0, 0, 8'h00, 2, 1);
        drive(0, 1, 8'hAB, 2, 1);
        drive(1, 1, 8'hC3, 1, 1);
        check("prio_opcode", 64'(o_opcode), 64'hC);
        check("prio_address", 64'(o_address), 64'h0003);
        check("prio_complete", 64'(o_complete), 64'(0));
        drive(0, 0, 8'h00, 1, 1);
        drive(0, 1, 8'h55, 1, 1);
        check("prio_c1_complete", 64'(o_complete), 64'(1));
        check("prio_c1_address", 64'(o_address), 64'h0055);

        // Asynchronous reset between operands.
        drive(1, 0, 8'h62, 2, 0);
        drive(0, 0, 8'h00, 2, 0);
        drive(0, 1, 8'h11, 2, 0);
        #1;
        i_reset = 1'b1;
        #1;
        check("rst_complete", 64'(o_complete), 64'(0));
        check("rst_opcode", 64'(o_opcode), 64'(0));
        check("rst_address_z", 64'(o_address), 64'hFFFF);
        i_send_address = 1'b1;
        #1;
        check("rst_address_send", 64'(o_address), 64'h0000);
        @(negedge i_clock);
        #1;
        i_reset = 1'b0;

        // Operand load while EMPTY.
        drive(0, 1, 8'h77, 1, 1);
        check("empty_ignore_addr", 64'(o_address), 64'h0000);
        check("empty_ignore_cpl", 64'(o_complete), 64'(0));
        drive(0, 0, 8'h00, 0, 0);
        @(negedge i_clock);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/instruction_register_multi.md
INSTRUCTION_REGISTER_MULTI -- requirements
Module: instruction_register_multi

Interface
REQ-001 SHALL have parameter BUS_W, default 8, bus and instruction-byte width.
REQ-002 SHALL have parameter OPC_W, default 4, opcode field width (high bits of instruction byte); 1 <= OPC_W < BUS_W.
REQ-003 SHALL have parameter MAX_OPERANDS, default 2, maximum operand bytes following an instruction byte; >= 1.
REQ-004 SHALL derive ADDR_W = BUS_W*MAX_OPERANDS and CNT_W = clog2(MAX_OPERANDS+1).
REQ-005 SHALL have port i_clock  input  1  sole clock, rising edge.
REQ-006 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port i_bus  input  BUS_W  shared data bus.
REQ-008 SHALL have port i_load_instruction  input  1  capture instruction byte from i_bus.
REQ-009 SHALL have port i_load_operand  input  1  capture next operand byte from i_bus.
REQ-010 SHALL have port i_send_address  input  1  drive o_address onto bus.
REQ-011 SHALL have port i_operand_count  input  CNT_W  operand bytes required by current o_opcode, from instruction decoder.
REQ-012 SHALL have port o_opcode  output  OPC_W  registered opcode field.
REQ-013 SHALL have port o_address  output  ADDR_W  assembled address; high-Z when i_send_address=0.
REQ-014 SHALL have port o_complete  output  1  instruction fully assembled.
REQ-015 SHALL have port o_error  output  1  decoder requested more than MAX_OPERANDS.

Function
REQ-016 SHALL implement states EMPTY, DECODE, OPERAND, COMPLETE; o_complete=1 only in COMPLETE.
REQ-017 SHALL, on a rising edge with i_load_instruction=1 in any state, store i_bus, clear all operand bytes, operand index and o_error, and enter DECODE.
REQ-018 SHALL, in DECODE (exactly one cycle), sample i_operand_count: 0 -> COMPLETE; 1..MAX_OPERANDS -> latch count, OPERAND; >MAX_OPERANDS -> o_error=1, COMPLETE.
REQ-019 SHALL, in OPERAND on an edge with i_load_operand=1, write i_bus into operand slot [index] (slot 0 = least-significant byte) and increment index; when index reaches latched count, enter COMPLETE on that same edge.
REQ-020 SHALL ignore i_load_operand in EMPTY, DECODE and COMPLETE.
REQ-021 SHALL give i_load_instruction priority over i_load_operand when both are 1 on one edge.
REQ-022 SHALL form o_address as: latched count 0 or o_error=1 -> low (BUS_W-OPC_W) instruction bits zero-extended to ADDR_W; otherwise operand slots concatenated, unloaded slots zero.
REQ-023 SHALL drive o_address combinationally from registers whenever i_send_address=1, in any state, including partial instructions.
REQ-024 SHALL hold o_opcode at high OPC_W bits of the stored instruction byte until next load or reset.
REQ-025 SHALL hold state, operands and o_error in COMPLETE indefinitely until i_load_instruction or reset.
REQ-026 SHALL give o_complete latency: 2 edges after instruction load for count 0; 1 edge after final operand load otherwise.

Reset
REQ-027 SHALL, on i_reset=1 asynchronously and in any state (including mid-OPERAND), clear instruction byte, operand slots, index, latched count, o_error; state EMPTY; o_opcode=0, o_complete=0.
REQ-028 SHALL keep o_address high-Z during reset while i_send_address=0; drive 0 if i_send_address=1.
REQ-029 SHALL power up in the reset state without requiring a reset pulse.

Verification
REQ-030 Defaults, bus 0x2E loaded, count=0 -> o_opcode=0x2, o_complete=1 two edges later, o_address=0x000E with send, Z without.
REQ-031 Bus 0x31 loaded, count=2, operands 0x34 then 0x12 -> o_complete after second operand edge, o_address=0x1234, o_opcode=0x3.
REQ-032 Count=3 with MAX_OPERANDS=2 -> o_error=1, COMPLETE, o_address=short form; next instruction load clears o_error.
REQ-033 Load instruction and operand asserted same edge during OPERAND -> new instruction captured, operands cleared, state DECODE.
REQ-034 Reset asserted between first and second operand -> immediate EMPTY, all outputs zero/Z, no wait for clock edge.
REQ-035 Operand loads in COMPLETE and EMPTY -> no change to o_address or o_complete.
